regfile_32x32: RTL

REGFILE_32X32 -- requirements
Module: regfile_32x32

---
 rtl/regfile_32x32_register_32.sv | 31 +++
 rtl/regfile_32x32.sv | 122 ++++++++++++
 2 files changed

// File: rtl/regfile_32x32_register_32.sv
// register_32: one storage word of the register file.
// DATA_WIDTH D flip-flops with a load enable and an asynchronous,
// active-high clear.
// Ports:
//   clock  - rising-edge clock
//   clear  - asynchronous clear to zero, active high
//   enable - load d on the next rising edge
//   d      - data in
//   q      - stored data
module register_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage flops: clear dominates over any coincident load.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q <= {WIDTH{1'b0}};
    end else if (enable) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/regfile_32x32.sv
// regfile_32x32: 32 x DATA_WIDTH register file, one write port, two
// combinational read ports. r0 reads as zero and ignores writes.
// Optional write-to-read forwarding (BYPASS=1) makes a same-cycle
// write visible on a matching read port before the clock edge.
// Ports:
//   clock            - write clock (rising edge)
//   ctrl_reset       - asynchronous active-high clear of all registers
//   ctrl_writeEnable - write strobe
//   ctrl_writeReg    - write address
//   data_writeReg    - write data
//   ctrl_readRegA/B  - read addresses
//   data_readRegA/B  - read data
module regfile_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [4:0]            ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [4:0]            ctrl_readRegA,
  input  logic [4:0]            ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB
);

  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  // One-hot decode of an address, gated by an enable.
  function automatic logic [NUM_REGS-1:0] decode_onehot(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  en
  );
    logic [NUM_REGS-1:0] sel;
    sel = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = en && (addr == ADDR_WIDTH'(i));
    end
    return sel;
  endfunction

  logic [NUM_REGS-1:1]   write_sel_s;
  logic [NUM_REGS-1:0]   write_dec_s;
  logic [NUM_REGS-1:0]   read_sel_a_s;
  logic [NUM_REGS-1:0]   read_sel_b_s;
  logic [DATA_WIDTH-1:0] regs_s [NUM_REGS];
  logic [DATA_WIDTH-1:0] mux_a_s;
  logic [DATA_WIDTH-1:0] mux_b_s;
  logic                  fwd_a_s;
  logic                  fwd_b_s;

  // Write-select decode; bit 0 is dropped because r0 has no storage.
  always_comb begin
    write_dec_s = decode_onehot(ctrl_writeReg, ctrl_writeEnable);
    write_sel_s = write_dec_s[NUM_REGS-1:1];
  end

  // r0 is a constant zero rather than a flop.
  assign regs_s[0] = {DATA_WIDTH{1'b0}};

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      register_32 #(.WIDTH(DATA_WIDTH)) u_reg (
        .clock  (clock),
        .clear  (ctrl_reset),
        .enable (write_sel_s[gi]),
        .d      (data_writeReg),
        .q      (regs_s[gi])
      );
    end
  endgenerate

  // Read decoders feeding the AND-OR selection trees.
  always_comb begin
    read_sel_a_s = decode_onehot(ctrl_readRegA, 1'b1);
    read_sel_b_s = decode_onehot(ctrl_readRegB, 1'b1);
  end

  // 32:1 AND-OR selection for both read ports.
  always_comb begin
    mux_a_s = {DATA_WIDTH{1'b0}};
    mux_b_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      mux_a_s = mux_a_s | (regs_s[i] & {DATA_WIDTH{read_sel_a_s[i]}});
      mux_b_s = mux_b_s | (regs_s[i] & {DATA_WIDTH{read_sel_b_s[i]}});
    end
  end

  // Forwarding qualifiers: never for r0, never while reset is held.
  always_comb begin
    fwd_a_s = (BYPASS != 0) && ctrl_writeEnable && !ctrl_reset &&
              (ctrl_readRegA == ctrl_writeReg) && (ctrl_readRegA != 5'd0);
    fwd_b_s = (BYPASS != 0) && ctrl_writeEnable && !ctrl_reset &&
              (ctrl_readRegB == ctrl_writeReg) && (ctrl_readRegB != 5'd0);
  end

  // Port A output: reset forces zero, then forwarding, then storage.
  always_comb begin
    if (ctrl_reset) begin
      data_readRegA = {DATA_WIDTH{1'b0}};
    end else if (fwd_a_s) begin
      data_readRegA = data_writeReg;
    end else begin
      data_readRegA = mux_a_s;
    end
  end

  // Port B output: same priority as port A.
  always_comb begin
    if (ctrl_reset) begin
      data_readRegB = {DATA_WIDTH{1'b0}};
    end else if (fwd_b_s) begin
      data_readRegB = data_writeReg;
    end else begin
      data_readRegB = mux_b_s;
    end
  end

endmodule
